// File: rtl/raystore_loader_pkg.sv
// Shared ray-tracer types and constants used by the raystore loader and its free list.
package raystore_loader_pkg;

    localparam int NUM_RAYS = 512;
    localparam int ID_W     = $clog2(NUM_RAYS);

    typedef logic [ID_W-1:0] rayID_t;

    typedef struct packed {
        logic [15:0] org_x;
        logic [15:0] org_y;
        logic [15:0] org_z;
        logic [15:0] dir_x;
        logic [15:0] dir_y;
        logic [15:0] dir_z;
    } ray_vec_t;

    localparam int RAY_W = $bits(ray_vec_t);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } loader_state_t;

    function automatic rayID_t next_id_ptr(input rayID_t p);
        rayID_t n;
        if (p == rayID_t'(NUM_RAYS - 1)) begin
            n = {ID_W{1'b0}};
        end else begin
            n = p + rayID_t'(1);
        end
        return n;
    endfunction

endpackage

// File: rtl/raystore_free_list.sv
// Circular FIFO of free rayIDs; head entry is presented combinationally for popping.
module raystore_free_list
    import raystore_loader_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  rayID_t        push_id,
    input  logic          pop,
    output rayID_t        pop_id,
    output logic [ID_W:0] count
);

    rayID_t        mem_r [NUM_RAYS];
    rayID_t        head_r;
    rayID_t        tail_r;
    logic [ID_W:0] count_r;

    // ID storage; entries beyond the count are never read, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[tail_r] <= push_id;
        end
    end

    // Head/tail pointers and occupancy count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_r  <= {ID_W{1'b0}};
            tail_r  <= {ID_W{1'b0}};
            count_r <= {(ID_W+1){1'b0}};
        end else begin
            if (push) begin
                tail_r <= next_id_ptr(tail_r);
            end
            if (pop) begin
                head_r <= next_id_ptr(head_r);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + (ID_W+1)'(1);
                2'b01:   count_r <= count_r - (ID_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign pop_id = mem_r[head_r];
    assign count  = count_r;

endmodule

// File: rtl/raystore_loader.sv
// Raystore write-side loader: assigns free rayIDs, writes the raystore, then hands IDs to traversal.
// Optional macro RAYSTORE_LOADER_THROTTLE_EN limits raystore writes to every other cycle.
module raystore_loader
    import raystore_loader_pkg::*;
#(
    parameter int OUT_DEPTH = 2
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [RAY_W-1:0] raygen_to_loader,
    input  logic             raygen_to_loader_valid,
    output logic             raygen_to_loader_stall,
    input  logic [ID_W-1:0]  retire_rayID,
    input  logic             retire_valid,
    output logic             retire_stall,
    output logic [ID_W-1:0]  loader_to_trav_rayID,
    output logic             loader_to_trav_valid,
    input  logic             loader_to_trav_stall,
    output logic             raystore_we,
    output logic [ID_W-1:0]  raystore_write_addr,
    output logic [RAY_W-1:0] raystore_write_data,
    output logic [ID_W:0]    num_free,
    output logic             overflow_err
);

    localparam int OCW = $clog2(OUT_DEPTH + 1);
    localparam int OPW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    loader_state_t  state_r;
    loader_state_t  state_nxt_s;
    rayID_t         init_cnt_r;
    logic           fl_push_s;
    rayID_t         fl_push_id_s;
    rayID_t         fl_pop_id_s;
    logic [ID_W:0]  fl_count_s;
    logic           fl_full_s;
    logic           fl_empty_s;
    logic           accept_s;
    logic           ovf_set_s;
    logic           throttle_s;
    logic           credit_ok_s;
    logic [OCW:0]   occupancy_s;
    logic           we_r;
    rayID_t         addr_r;
    ray_vec_t       data_r;
    logic           ovf_r;
    rayID_t         ofifo_mem_r [OUT_DEPTH];
    logic [OPW-1:0] ofifo_wr_r;
    logic [OPW-1:0] ofifo_rd_r;
    logic [OCW-1:0] ofifo_cnt_r;
    logic           ofifo_pop_s;

    function automatic logic [OPW-1:0] ofifo_next(input logic [OPW-1:0] p);
        logic [OPW-1:0] n;
        if (p == OPW'(OUT_DEPTH - 1)) begin
            n = {OPW{1'b0}};
        end else begin
            n = p + OPW'(1);
        end
        return n;
    endfunction

    raystore_free_list u_free_list (
        .clk     (clk),
        .rst     (rst),
        .push    (fl_push_s),
        .push_id (fl_push_id_s),
        .pop     (accept_s),
        .pop_id  (fl_pop_id_s),
        .count   (fl_count_s)
    );

`ifdef RAYSTORE_LOADER_THROTTLE_EN
    assign throttle_s = we_r;
`else
    assign throttle_s = 1'b0;
`endif

    assign fl_full_s   = (fl_count_s == (ID_W+1)'(NUM_RAYS));
    assign fl_empty_s  = (fl_count_s == (ID_W+1)'(0));
    assign ofifo_pop_s = (ofifo_cnt_r != OCW'(0)) & ~loader_to_trav_stall;
    // A same-cycle output pop frees a slot, which keeps a depth-2 FIFO at one ray per cycle.
    assign occupancy_s = {1'b0, ofifo_cnt_r} + (OCW+1)'(we_r) - (OCW+1)'(ofifo_pop_s);
    assign credit_ok_s = (occupancy_s < (OCW+1)'(OUT_DEPTH));

    // Next-state, accept and free-list push selection.
    always_comb begin
        state_nxt_s            = state_r;
        raygen_to_loader_stall = raygen_to_loader_valid;
        retire_stall           = retire_valid;
        fl_push_s              = 1'b0;
        fl_push_id_s           = retire_rayID;
        accept_s               = 1'b0;
        ovf_set_s              = 1'b0;
        case (state_r)
            ST_INIT: begin
                fl_push_s    = 1'b1;
                fl_push_id_s = init_cnt_r;
                if (init_cnt_r == rayID_t'(NUM_RAYS - 1)) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_RUN: begin
                accept_s = raygen_to_loader_valid & ~fl_empty_s & credit_ok_s & ~throttle_s;
                raygen_to_loader_stall = raygen_to_loader_valid & ~accept_s;
                retire_stall = 1'b0;
                fl_push_s    = retire_valid & ~fl_full_s;
                ovf_set_s    = retire_valid & fl_full_s;
            end
            default: begin
                state_nxt_s = ST_INIT;
            end
        endcase
    end

    // State register and init fill counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_INIT;
            init_cnt_r <= {ID_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_INIT) begin
                init_cnt_r <= init_cnt_r + rayID_t'(1);
            end else begin
                init_cnt_r <= {ID_W{1'b0}};
            end
        end
    end

    // Raystore write port register and sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_r   <= 1'b0;
            addr_r <= {ID_W{1'b0}};
            data_r <= {RAY_W{1'b0}};
            ovf_r  <= 1'b0;
        end else begin
            we_r <= accept_s;
            if (accept_s) begin
                addr_r <= fl_pop_id_s;
                data_r <= raygen_to_loader;
            end
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // Output FIFO: IDs enter one cycle after their raystore write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ofifo_wr_r  <= {OPW{1'b0}};
            ofifo_rd_r  <= {OPW{1'b0}};
            ofifo_cnt_r <= {OCW{1'b0}};
            for (int i = 0; i < OUT_DEPTH; i++) begin
                ofifo_mem_r[i] <= {ID_W{1'b0}};
            end
        end else begin
            if (we_r) begin
                ofifo_mem_r[ofifo_wr_r] <= addr_r;
                ofifo_wr_r              <= ofifo_next(ofifo_wr_r);
            end
            if (ofifo_pop_s) begin
                ofifo_rd_r <= ofifo_next(ofifo_rd_r);
            end
            case ({we_r, ofifo_pop_s})
                2'b10:   ofifo_cnt_r <= ofifo_cnt_r + OCW'(1);
                2'b01:   ofifo_cnt_r <= ofifo_cnt_r - OCW'(1);
                default: ofifo_cnt_r <= ofifo_cnt_r;
            endcase
        end
    end

    assign raystore_we          = we_r;
    assign raystore_write_addr  = addr_r;
    assign raystore_write_data  = data_r;
    assign loader_to_trav_valid = (ofifo_cnt_r != OCW'(0));
    assign loader_to_trav_rayID = ofifo_mem_r[ofifo_rd_r];
    assign num_free             = fl_count_s;
    assign overflow_err         = ovf_r;

endmodule

// File: tb/tb_raystore_loader.sv
// Bench for raystore_loader: free-list model plus write/traversal scoreboards and directed sequences.
module tb_raystore_loader;
    import raystore_loader_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [RAY_W-1:0] ray;
    logic             ray_valid;
    logic             ray_stall;
    rayID_t           retire_id;
    logic             retire_valid;
    logic             retire_stall;
    rayID_t           trav_id;
    logic             trav_valid;
    logic             trav_stall;
    logic             we;
    rayID_t           waddr;
    logic [RAY_W-1:0] wdata;
    logic [ID_W:0]    num_free;
    logic             overflow_err;

    always #5 clk = ~clk;

    raystore_loader dut (
        .clk                    (clk),
        .rst                    (rst),
        .raygen_to_loader       (ray),
        .raygen_to_loader_valid (ray_valid),
        .raygen_to_loader_stall (ray_stall),
        .retire_rayID           (retire_id),
        .retire_valid           (retire_valid),
        .retire_stall           (retire_stall),
        .loader_to_trav_rayID   (trav_id),
        .loader_to_trav_valid   (trav_valid),
        .loader_to_trav_stall   (trav_stall),
        .raystore_we            (we),
        .raystore_write_addr    (waddr),
        .raystore_write_data    (wdata),
        .num_free               (num_free),
        .overflow_err           (overflow_err)
    );

    typedef struct packed {
        rayID_t           id;
        logic [RAY_W-1:0] data;
    } wr_t;

    typedef struct {
        logic vld;
        logic tstall;
        logic e_stall;
        logic e_we;
        logic e_tvalid;
    } vec_t;

    int     n_checks = 0;
    int     n_fail   = 0;
    logic   run_phase = 1'b0;
    logic   exp_ovf  = 1'b0;
    logic   model_full;
    rayID_t mfree [$];
    rayID_t tq [$];
    wr_t    wq [$];
    wr_t    w_pop;
    rayID_t t_pop;
    vec_t   tbl [13];
    logic [RAY_W-1:0] held_ray;
    int     accepted;
    int     cyc;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RAY_W-1:0] rnd_ray();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    // Scoreboard: model free list, expected writes and expected traversal IDs.
    always @(negedge clk) begin
        if (run_phase) begin
            check("num_free_model", num_free, mfree.size());
            check("overflow_model", overflow_err, exp_ovf);
            check("write_expected", we, wq.size() != 0);
            if (we && wq.size() != 0) begin
                w_pop = wq.pop_front();
                check("write_addr", waddr, w_pop.id);
                check("write_data", wdata, w_pop.data);
            end
            if (trav_valid && !trav_stall) begin
                check("trav_pending", tq.size() > 0, 1);
                if (tq.size() > 0) begin
                    t_pop = tq.pop_front();
                    check("trav_rayID", trav_id, t_pop);
                end
            end
            model_full = (mfree.size() == NUM_RAYS);
            if (ray_valid && !ray_stall) begin
                check("accept_has_free", mfree.size() > 0, 1);
                if (mfree.size() > 0) begin
                    t_pop = mfree.pop_front();
                    wq.push_back('{id: t_pop, data: ray});
                    tq.push_back(t_pop);
                end
            end
            if (retire_valid && !retire_stall) begin
                if (model_full) exp_ovf = 1'b1;
                else mfree.push_back(retire_id);
            end
        end
    end

    task automatic do_reset();
        run_phase    = 1'b0;
        rst          = 1'b0;
        ray_valid    = 1'b0;
        retire_valid = 1'b0;
        trav_stall   = 1'b0;
        ray          = {RAY_W{1'b0}};
        retire_id    = {ID_W{1'b0}};
        mfree.delete();
        wq.delete();
        tq.delete();
        exp_ovf = 1'b0;
        for (int i = 0; i < NUM_RAYS; i++) mfree.push_back(rayID_t'(i));
        #1;
        check("rst_we", we, 0);
        check("rst_addr", waddr, 0);
        check("rst_data", wdata, 0);
        check("rst_trav_valid", trav_valid, 0);
        check("rst_num_free", num_free, 0);
        check("rst_overflow", overflow_err, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= NUM_RAYS; i++) begin
            tick();
            if (i == NUM_RAYS - 1) check("init_num_free_511", num_free, NUM_RAYS - 1);
            if (i < NUM_RAYS) begin
                ray_valid    = 1'($urandom_range(0, 1));
                retire_valid = 1'($urandom_range(0, 1));
                retire_id    = rayID_t'($urandom_range(0, NUM_RAYS - 1));
                #1;
                check("init_raygen_stall", ray_stall, ray_valid);
                check("init_retire_stall", retire_stall, retire_valid);
                check("init_we", we, 0);
            end
        end
        ray_valid    = 1'b0;
        retire_valid = 1'b0;
        check("run_num_free", num_free, NUM_RAYS);
        run_phase = 1'b1;
    endtask

    initial begin
        // Reset and init fill
        do_reset();

        // Single ray
        held_ray  = 96'h0123_4567_89ab_cdef_0246_8ace;
        ray       = held_ray;
        ray_valid = 1'b1;
        #1;
        check("single_stall", ray_stall, 0);
        tick();
        ray_valid = 1'b0;
        check("single_we", we, 1);
        check("single_addr", waddr, 0);
        check("single_data", wdata, held_ray);
        check("single_trav_early", trav_valid, 0);
        tick();
        check("single_we_once", we, 0);
        check("single_trav_valid", trav_valid, 1);
        check("single_trav_id", trav_id, 0);
        check("single_num_free", num_free, NUM_RAYS - 1);
        tick();

        // Exhaustion after a fresh init
        do_reset();
        ray_valid = 1'b1;
        accepted  = 0;
        cyc       = 0;
        while (accepted < NUM_RAYS && cyc < 1200) begin
            ray = rnd_ray();
            #1;
`ifndef RAYSTORE_LOADER_THROTTLE_EN
            check("b2b_no_stall", ray_stall, 0);
`endif
            if (!ray_stall) accepted++;
            tick();
            cyc++;
        end
        check("exhaust_accepted", accepted, NUM_RAYS);
        held_ray = rnd_ray();
        ray      = held_ray;
        #1;
        check("exhaust_stall", ray_stall, 1);
        check("exhaust_num_free", num_free, 0);

        // Recovery: retire 37 while empty, pending ray gets it next cycle
        retire_id    = rayID_t'(37);
        retire_valid = 1'b1;
        #1;
        check("retire_same_cycle_stall", ray_stall, 1);
        tick();
        retire_valid = 1'b0;
        #1;
        check("recovery_accept", ray_stall, 0);
        check("recovery_num_free", num_free, 1);
        tick();
        ray_valid = 1'b0;
        check("recovery_we", we, 1);
        check("recovery_addr", waddr, 37);
        check("recovery_data", wdata, held_ray);
        check("recovery_num_free_0", num_free, 0);
        retire_id    = rayID_t'(100);
        retire_valid = 1'b1;
        tick();
        retire_valid = 1'b0;
        tick();
        check("pre_simul_num_free", num_free, 1);
        ray          = rnd_ray();
        ray_valid    = 1'b1;
        retire_id    = rayID_t'(5);
        retire_valid = 1'b1;
        #1;
        check("simul_accept", ray_stall, 0);
        tick();
        ray_valid    = 1'b0;
        retire_valid = 1'b0;
        check("simul_num_free", num_free, 1);
        check("simul_addr", waddr, 100);

`ifndef RAYSTORE_LOADER_THROTTLE_EN
        // Output backpressure, cycle by cycle
        for (int k = 0; k < 4; k++) begin
            retire_id    = rayID_t'(200 + k);
            retire_valid = 1'b1;
            tick();
        end
        retire_valid = 1'b0;
        tick();
        tick();
        check("bp_pre_free", num_free, 5);
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int r = 3; r < 10; r++) tbl[r] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int r = 0; r < 13; r++) begin
            ray_valid  = tbl[r].vld;
            trav_stall = tbl[r].tstall;
            ray        = rnd_ray();
            #1;
            check("bp_raygen_stall", ray_stall, tbl[r].e_stall);
            check("bp_we", we, tbl[r].e_we);
            check("bp_trav_valid", trav_valid, tbl[r].e_tvalid);
            tick();
        end
`endif
        ray_valid  = 1'b0;
        trav_stall = 1'b0;
        repeat (6) tick();
        check("drain_writes", wq.size(), 0);
        check("drain_trav", tq.size(), 0);

        // Overflow at full list, then write cadence from a fresh start
        do_reset();
        retire_id    = rayID_t'(7);
        retire_valid = 1'b1;
        tick();
        retire_valid = 1'b0;
        check("ovf_set", overflow_err, 1);
        check("ovf_num_free", num_free, NUM_RAYS);
        tick();
        tick();
        check("ovf_sticky", overflow_err, 1);
        ray_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            ray = rnd_ray();
            #1;
`ifdef RAYSTORE_LOADER_THROTTLE_EN
            check("thr_we", we, k % 2);
            check("thr_stall", ray_stall, k % 2);
`else
            check("cadence_we", we, k != 0);
            check("cadence_stall", ray_stall, 0);
`endif
            tick();
        end
        ray_valid = 1'b0;
        repeat (6) tick();
        check("final_writes", wq.size(), 0);
        check("final_trav", tq.size(), 0);

        // Reset clears the sticky flag
        do_reset();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
